round_ctrl: RTL and testbench

Game-round controller that drives the two control lines of the 30-second countdown timer and consumes its `time_out` flag. It sequences a fixed number of answer rounds: it reloads the timer, lets it run, supports pausing, and closes each round on a player answer or a timeout. It also keeps the round count and score. It sits beside the countdown timer in the top level, shares its 1 s tick, and feeds the score and round values to the display logic.

---
 rtl/round_ctrl_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 45 ++++
 rtl/round_ctrl.sv | 106 ++++++++++
 tb/tb_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_ctrl_pkg.sv
// Shared types and encodings for the game-round controller and its helpers.
// The timer_ctl codes map directly onto the countdown timer's A[2:1] lines.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSED,
    ROUND_END,
    GAME_OVER
  } state_t;

  // A[1] is an active-low reload; A[2] high freezes the count.
  localparam logic [1:0] TC_RELOAD = 2'b10;
  localparam logic [1:0] TC_RUN    = 2'b01;
  localparam logic [1:0] TC_HOLD   = 2'b11;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  function automatic logic [1:0] tc_for_state(input state_t s);
    logic [1:0] tc;
    case (s)
      RUN:     tc = TC_RUN;
      PAUSED:  tc = TC_HOLD;
      default: tc = TC_RELOAD;
    endcase
    return tc;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low push-button to single-cycle press pulse.
// The chain is a 2-flop synchronizer, a stability counter and a falling-edge detector.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_50,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_50 or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] != level) begin
        // The new level must hold for DEBOUNCE_CYCLES consecutive cycles.
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
          press <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Game-round controller: sequences answer rounds around the 30 s countdown,
// drives its reload/freeze lines and keeps round number and score.
module round_ctrl #(
  parameter int NUM_ROUNDS      = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock_50,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       start_n,
  input  logic       pause_n,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic       time_out,
  output logic [1:0] timer_ctl,
  output logic [3:0] round,
  output logic [3:0] score,
  output logic       running,
  output logic       game_over
);

  import round_ctrl_pkg::*;

  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] round_d, score_d;
  logic       start_press, pause_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
    .clock_50 (clock_50),
    .rst      (rst),
    .btn_n    (start_n),
    .press    (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
    .clock_50 (clock_50),
    .rst      (rst),
    .btn_n    (pause_n),
    .press    (pause_press)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    round_d = round;
    score_d = score;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_press) begin
          state_d = LOAD;
          round_d = 4'd1;
          score_d = 4'd0;
        end
      end
      LOAD: begin
        // The countdown reloads on the tick edge, so only then is it safe to run.
        if (sec_tick) state_d = RUN;
      end
      RUN: begin
        if (answer_valid) begin
          state_d = ROUND_END;
          if (answer_correct && score != SCORE_MAX) score_d = score + 4'd1;
        end else if (time_out) begin
          state_d = ROUND_END;
        end else if (pause_press) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_press) state_d = RUN;
      end
      ROUND_END: begin
        if (round >= ROUND_LAST) begin
          state_d = GAME_OVER;
        end else begin
          state_d = LOAD;
          round_d = round + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change in step with it.
  always_ff @(posedge clock_50 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      round     <= 4'd0;
      score     <= 4'd0;
      timer_ctl <= TC_RELOAD;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      round     <= round_d;
      score     <= score_d;
      timer_ctl <= tc_for_state(state_d);
      running   <= (state_d == RUN);
      game_over <= (state_d == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus queues expected output snapshots,
// a monitor pops one on every observed change of the output bundle.
module tb_round_ctrl;
  import round_ctrl_pkg::*;

  localparam int NR = 4;

  logic       clock_50;
  logic       rst;
  logic       sec_tick;
  logic       start_n;
  logic       pause_n;
  logic       answer_valid;
  logic       answer_correct;
  logic       time_out;
  logic [1:0] timer_ctl;
  logic [3:0] round;
  logic [3:0] score;
  logic       running;
  logic       game_over;

  round_ctrl #(.NUM_ROUNDS(NR), .DEBOUNCE_CYCLES(4)) dut (
    .clock_50       (clock_50),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .start_n        (start_n),
    .pause_n        (pause_n),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .time_out       (time_out),
    .timer_ctl      (timer_ctl),
    .round          (round),
    .score          (score),
    .running        (running),
    .game_over      (game_over)
  );

  typedef struct {
    string       name;
    logic [11:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] m_round, m_score;

  initial begin
    clock_50 = 1'b0;
    forever #5 clock_50 = ~clock_50;
  end

  initial begin
    int tick_cnt;
    tick_cnt = 0;
    sec_tick = 1'b0;
    forever begin
      @(posedge clock_50);
      #1;
      tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
      sec_tick = (tick_cnt == 9);
    end
  end

  function automatic logic [11:0] mk(input logic [1:0] tc, input logic [3:0] r,
                                     input logic [3:0] s, input logic run, input logic go);
    return {tc, r, s, run, go};
  endfunction

  function automatic logic [11:0] bundle();
    return {timer_ctl, round, score, running, game_over};
  endfunction

  task automatic check(input bit ok, input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual={tc,round,score,run,go}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [11:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clock_50);
      n++;
    end
    check(q.size() == 0, name, 12'(q.size()), 12'd0);
  endtask

  task automatic press(input bit is_start);
    @(posedge clock_50);
    #1;
    if (is_start) start_n = 1'b0; else pause_n = 1'b0;
    repeat (8) @(posedge clock_50);
    #1;
    start_n = 1'b1;
    pause_n = 1'b1;
    repeat (8) @(posedge clock_50);
  endtask

  task automatic start_game(input string name);
    m_round = 4'd1;
    m_score = 4'd0;
    push({name, "_load"}, mk(TC_RELOAD, 4'd1, 4'd0, 1'b0, 1'b0));
    push({name, "_run"},  mk(TC_RUN,    4'd1, 4'd0, 1'b1, 1'b0));
    press(1'b1);
    drain({name, "_drain"});
  endtask

  task automatic play_round(input bit valid, input bit correct, input bit tout,
                            input string name);
    logic [3:0]  ns;
    logic [11:0] re_val, after_val;
    ns = (valid && correct && m_score != 4'd15) ? m_score + 4'd1 : m_score;
    re_val = mk(TC_RELOAD, m_round, ns, 1'b0, 1'b0);
    if (m_round == 4'(NR)) after_val = mk(TC_RELOAD, m_round, ns, 1'b0, 1'b1);
    else                   after_val = mk(TC_RELOAD, m_round + 4'd1, ns, 1'b0, 1'b0);
    push({name, "_round_end"}, re_val);
    push({name, "_after"}, after_val);
    if (m_round != 4'(NR)) push({name, "_run"}, mk(TC_RUN, m_round + 4'd1, ns, 1'b1, 1'b0));
    @(posedge clock_50);
    #1;
    answer_valid   = valid;
    answer_correct = correct;
    time_out       = tout;
    @(posedge clock_50);
    #1;
    answer_valid   = 1'b0;
    answer_correct = 1'b0;
    time_out       = 1'b0;
    @(negedge clock_50);
    check(bundle() === re_val, {name, "_re_now"}, bundle(), re_val);
    @(negedge clock_50);
    check(bundle() === after_val, {name, "_re_one_cycle"}, bundle(), after_val);
    m_score = ns;
    if (m_round != 4'(NR)) m_round = m_round + 4'd1;
    drain({name, "_drain"});
  endtask

  // Monitor: every change in the visible outputs must match the next queued snapshot.
  initial begin
    logic [11:0] last, cur;
    exp_t e;
    last = mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0);
    forever begin
      @(negedge clock_50);
      cur = bundle();
      if (cur !== last) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_change", cur, last);
        end else begin
          e = q.pop_front();
          check(cur === e.val, e.name, cur, e.val);
        end
        last = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    start_n        = 1'b1;
    pause_n        = 1'b1;
    answer_valid   = 1'b0;
    answer_correct = 1'b0;
    time_out       = 1'b0;
    m_round        = 4'd0;
    m_score        = 4'd0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clock_50);
    #2 rst = 1'b1;
    @(negedge clock_50);
    check(bundle() === mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0), "reset_state",
          bundle(), mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0));

    // Game 1: correct, pause/resume, wrong, answer+timeout, timeout.
    start_game("g1_start");
    check(bundle() === mk(TC_RUN, 4'd1, 4'd0, 1'b1, 1'b0), "g1_in_run",
          bundle(), mk(TC_RUN, 4'd1, 4'd0, 1'b1, 1'b0));
    play_round(1'b1, 1'b1, 1'b0, "g1_r1_correct");

    push("pause", mk(TC_HOLD, 4'd2, 4'd1, 1'b0, 1'b0));
    press(1'b0);
    drain("pause_drain");
    @(posedge clock_50);
    #1;
    answer_valid   = 1'b1;
    answer_correct = 1'b1;
    time_out       = 1'b1;
    @(posedge clock_50);
    #1;
    answer_valid   = 1'b0;
    answer_correct = 1'b0;
    time_out       = 1'b0;
    repeat (5) @(posedge clock_50);
    @(negedge clock_50);
    check(bundle() === mk(TC_HOLD, 4'd2, 4'd1, 1'b0, 1'b0), "paused_ignores",
          bundle(), mk(TC_HOLD, 4'd2, 4'd1, 1'b0, 1'b0));
    push("resume", mk(TC_RUN, 4'd2, 4'd1, 1'b1, 1'b0));
    press(1'b0);
    drain("resume_drain");

    play_round(1'b1, 1'b0, 1'b0, "g1_r2_wrong");
    play_round(1'b1, 1'b1, 1'b1, "g1_r3_answer_beats_timeout");
    play_round(1'b0, 1'b0, 1'b1, "g1_r4_timeout");
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    check(bundle() === mk(TC_RELOAD, 4'd4, 4'd2, 1'b0, 1'b1), "game_over_hold",
          bundle(), mk(TC_RELOAD, 4'd4, 4'd2, 1'b0, 1'b1));

    // Game 2: restart, ignored start in RUN, three correct, reset mid-RUN.
    start_game("g2_start");
    press(1'b1);
    @(negedge clock_50);
    check(bundle() === mk(TC_RUN, 4'd1, 4'd0, 1'b1, 1'b0), "start_ignored_in_run",
          bundle(), mk(TC_RUN, 4'd1, 4'd0, 1'b1, 1'b0));
    play_round(1'b1, 1'b1, 1'b0, "g2_r1");
    play_round(1'b1, 1'b1, 1'b0, "g2_r2");
    play_round(1'b1, 1'b1, 1'b0, "g2_r3");
    check(bundle() === mk(TC_RUN, 4'd4, 4'd3, 1'b1, 1'b0), "g2_before_reset",
          bundle(), mk(TC_RUN, 4'd4, 4'd3, 1'b1, 1'b0));

    @(posedge clock_50);
    #2;
    push("mid_run_reset", mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check(bundle() === mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0), "async_reset_immediate",
          bundle(), mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0));
    repeat (2) @(posedge clock_50);
    #2 rst = 1'b1;
    drain("reset_drain");

    // A start glitch shorter than the debounce window must not start a game.
    @(posedge clock_50);
    #1 start_n = 1'b0;
    repeat (2) @(posedge clock_50);
    #1 start_n = 1'b1;
    repeat (20) @(posedge clock_50);
    @(negedge clock_50);
    check(bundle() === mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0), "glitch_stays_idle",
          bundle(), mk(TC_RELOAD, 4'd0, 4'd0, 1'b0, 1'b0));
    check(q.size() == 0, "queue_empty_at_end", 12'(q.size()), 12'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
